instr_fetch_unit: RTL and testbench

Instruction fetch unit for the single-issue MIPS datapath. It owns the program counter and fetches 32-bit words from instruction memory over a request/acknowledge handshake. Each word is presented to the decode stage, where the control unit consumes `instr_op`, over a valid/ready handshake. It accepts resolved branch outcomes from the datapath (control-unit `branch` ANDed with ALU zero) and redirects the PC, discarding any wrong-path fetch in flight.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and presents words to decode.
// Optional IFU_JUMP_EN: opcode 6'b000010 (j) is executed inside fetch and never presented.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  instr_op,
    output logic [31:0] instr_pc_plus4,
    input  logic        resolve_valid,
    input  logic        resolve_branch,
    input  logic        resolve_zero,
    input  logic [31:0] resolve_pc_plus4,
    input  logic [15:0] resolve_imm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] jump_target_s;
    logic        is_jump_s;

    assign redirect_s    = resolve_valid & resolve_branch & resolve_zero;
    assign target_s      = resolve_pc_plus4 + {{14{resolve_imm[15]}}, resolve_imm, 2'b00};
    assign pc_plus4_s    = pc_q + 32'd4;
    assign jump_target_s = {pc_plus4_s[31:28], imem_rdata[25:0], 2'b00};

`ifdef IFU_JUMP_EN
    assign is_jump_s = (imem_rdata[31:26] == 6'b000010);
`else
    assign is_jump_s = 1'b0;
`endif

    // Next-state and datapath updates; a resolved taken branch always takes priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_s) begin
                    // With no ack yet the response is still owed, so drain it first.
                    pc_d    = target_s;
                    state_d = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    if (is_jump_s) begin
                        pc_d    = jump_target_s;
                        state_d = ST_FETCH;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4_s;
                        pc_d    = pc_plus4_s;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    valid_d = 1'b0;
                    pc_d    = target_s;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redirect_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req       = (state_q == ST_FETCH);
    assign imem_addr      = pc_q;
    assign instr_valid    = valid_q;
    assign instr          = instr_q;
    assign instr_op       = instr_q[31:26];
    assign instr_pc_plus4 = pc4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed scenarios followed by randomized branch/backpressure traffic.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  instr_op;
    logic [31:0] instr_pc_plus4;
    logic        resolve_valid;
    logic        resolve_branch;
    logic        resolve_zero;
    logic [31:0] resolve_pc_plus4;
    logic [15:0] resolve_imm;

    int checks = 0;
    int errors = 0;
    int xfer_count = 0;
    int mem_delay = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];

    instr_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_op(instr_op),
        .instr_pc_plus4(instr_pc_plus4),
        .resolve_valid(resolve_valid), .resolve_branch(resolve_branch), .resolve_zero(resolve_zero),
        .resolve_pc_plus4(resolve_pc_plus4), .resolve_imm(resolve_imm)
    );

    always #5 clk = ~clk;

    // Memory image: a fixed load word low in memory, a jump at 0x600, hashed words elsewhere (never j).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a < 32'h0000_0080) begin
            w = 32'h8C01_0004;
        end else if (a == 32'h0000_0600) begin
            w = 32'h0800_0010;
        end else begin
            w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
            if (w[31:26] == 6'b000010) w[31:26] = 6'b000011;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Reference model: the queue holds the addresses decode should see next, in program order.
    task automatic refill();
        logic [31:0] w;
        while (exp_q.size() < 3) begin
            w = mem_word(model_pc);
`ifdef IFU_JUMP_EN
            if (w[31:26] == 6'b000010) begin
                model_pc = {model_pc[31:28] + ((model_pc[27:0] > 28'hFFF_FFFB) ? 4'd1 : 4'd0),
                            w[25:0], 2'b00};
                continue;
            end
`endif
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic rb, input logic rz,
                        input logic [31:0] pp4, input logic [15:0] imm);
        logic [31:0] head;
        logic        keep;
        instr_ready      = rdy;
        resolve_valid    = rv;
        resolve_branch   = rb;
        resolve_zero     = rz;
        resolve_pc_plus4 = pp4;
        resolve_imm      = imm;
        if (rv && rb && rz) begin
            keep = instr_valid && rdy && (exp_q.size() > 0);
            head = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
            exp_q.delete();
            if (keep) exp_q.push_back(head);
            model_pc = pp4 + {{14{imm[15]}}, imm, 2'b00};
        end
        refill();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(rdy, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) break;
            idle(1'b0);
        end
        check1("reach_hold", instr_valid, 1'b1);
    endtask

    // Instruction memory: one outstanding request, configurable or random ack latency.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int          cnt;
        pend = 1'b0; pend_addr = 32'h0; cnt = 0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend && imem_req) check("addr_stable", imem_addr, pend_addr);
                if (!pend && imem_req) begin
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    req_log.push_back(imem_addr);
                    cnt = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
                end else if (pend && cnt > 0) begin
                    cnt--;
                end
                if (pend && cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(pend_addr);
                    pend       = 1'b0;
                end
            end
        end
    end

    // Monitor: every completed decode transfer must match the head of the expected stream.
    initial begin
        logic [31:0] a;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                xfer_count++;
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    a = exp_q.pop_front();
                    w = mem_word(a);
                    check("sb_instr", instr, w);
                    check("sb_pc_plus4", instr_pc_plus4, a + 32'd4);
                    check("sb_instr_op", {26'b0, instr_op}, {26'b0, w[31:26]});
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        int          xfer0;
        rst = 1'b1;
        instr_ready = 1'b0; resolve_valid = 1'b0; resolve_branch = 1'b0; resolve_zero = 1'b0;
        resolve_pc_plus4 = 32'h0; resolve_imm = 16'h0;
        model_pc = 32'h40;
        @(posedge clk);
        #1;
        repeat (3) idle(1'b0);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_plus4", instr_pc_plus4, 32'h0);
        check("rst_addr", imem_addr, 32'h40);

        // Sequential fetch from RESET_PC with zero-wait memory.
        rst = 1'b0;
        model_pc = 32'h40;
        exp_q.delete();
        req_log.delete();
        repeat (9) idle(1'b1);
        check("seq_addr0", req_log.size() > 0 ? req_log[0] : 32'hDEAD, 32'h40);
        check("seq_addr1", req_log.size() > 1 ? req_log[1] : 32'hDEAD, 32'h44);
        check("seq_addr2", req_log.size() > 2 ? req_log[2] : 32'hDEAD, 32'h48);

        // Backpressure: outputs stay put and no request is issued.
        wait_hold();
        for (int i = 0; i < 5; i++) begin
            check1("bp_valid", instr_valid, 1'b1);
            check1("bp_req", imem_req, 1'b0);
            check("bp_instr", instr, mem_word(exp_q[0]));
            check("bp_pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
            idle(1'b0);
        end
        idle(1'b1);

        // Taken branch in HOLD with a negative offset.
        wait_hold();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 16'hFFFE);
        check1("br_hold_valid", instr_valid, 1'b0);
        check1("br_hold_req", imem_req, 1'b1);
        check("br_hold_addr", imem_addr, 32'hF8);
        repeat (4) idle(1'b1);

        // Redirect while a slow fetch is outstanding: the late word is drained.
        mem_delay = 3;
        wait_hold();
        idle(1'b1);
        idle(1'b0);
        req_log.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 16'h0);
        check1("drain_req", imem_req, 1'b0);
        check1("drain_valid", instr_valid, 1'b0);
        repeat (10) idle(1'b1);
        check("drain_next_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD, 32'h200);

        // Redirect coincident with ack.
        wait_hold();
        mem_delay = 0;
        idle(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 16'h0);
        check1("coinc_req", imem_req, 1'b1);
        check("coinc_addr", imem_addr, 32'h200);
        check1("coinc_valid", instr_valid, 1'b0);
        repeat (4) idle(1'b1);

        // Partial resolve conditions must not redirect.
        wait_hold();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 16'h0);
        check1("nz_valid", instr_valid, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 16'h0);
        check1("nv_valid", instr_valid, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 16'h0);
        check1("nb_valid", instr_valid, 1'b1);
        repeat (4) idle(1'b1);

        // Target arithmetic wraps silently.
        wait_hold();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 16'h0001);
        check("wrap_addr", imem_addr, 32'h0);
        check1("wrap_req", imem_req, 1'b1);
        repeat (4) idle(1'b1);

        // Jump word at 0x600.
        wait_hold();
        req_log.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h600, 16'h0);
        repeat (6) idle(1'b1);
        check("jump_addr0", req_log.size() > 0 ? req_log[0] : 32'hDEAD, 32'h600);
`ifdef IFU_JUMP_EN
        check("jump_addr1", req_log.size() > 1 ? req_log[1] : 32'hDEAD, 32'h40);
`else
        check("jump_addr1", req_log.size() > 1 ? req_log[1] : 32'hDEAD, 32'h604);
`endif

        // Randomized traffic.
        mem_delay = -1;
        xfer0 = xfer_count;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom();
            r2 = $urandom();
            step(r2[16], (r2[18:17] != 2'b00), r2[19], r2[20], {r[31:2], 2'b00}, r2[15:0]);
        end
        check1("rand_progress", (xfer_count - xfer0) > 50, 1'b1);

        // Reset from an arbitrary state.
        rst = 1'b1;
        idle(1'b0);
        check1("rerst_req", imem_req, 1'b0);
        check1("rerst_valid", instr_valid, 1'b0);
        check("rerst_instr", instr, 32'h0);
        check("rerst_pc_plus4", instr_pc_plus4, 32'h0);
        check("rerst_addr", imem_addr, 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
